// File: rtl/extbus_xfer.sv
// extbus_xfer: moves one 72-bit word between a four-port buffer X port and external memory.
// Latency: accept -> done in 3 cycles with a zero-wait memory, plus one cycle per memory wait state.
// Backpressure: cmd_ready is high only in IDLE; the memory side stalls in MREQ until mem_ack.
//
// Ports:
//   clk, reset                          clock and synchronous active-high reset
//   cmd_valid/cmd_ready                 command handshake (accepted when both are high)
//   cmd_write, cmd_slot, cmd_addr       1 = store (slot -> memory), 0 = load (memory -> slot)
//   done, err                           one-cycle completion pulse and coincident timeout flag
//   AX, ECX, WX, xdata_o, xdata_i       buffer X port (address, enable, write enable, data)
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack       external memory request/response
//
// Optional feature: define EXTBUS_XFER_TIMEOUT_EN to abort a memory request after
// 255 cycles without mem_ack (done and err then pulse together, nothing is written).
// Without it MREQ waits forever and err is tied low.

module extbus_xfer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_slot,
    input  logic [19:0] cmd_addr,
    output logic        done,
    output logic        err,
    output logic [1:0]  AX,
    output logic        ECX,
    output logic        WX,
    output logic [71:0] xdata_o,
    input  logic [71:0] xdata_i,
    output logic        mem_req,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [71:0] mem_wdata,
    input  logic [71:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XRD  = 3'd1,
        ST_MREQ = 3'd2,
        ST_XWR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Command context latched on accept and held for the whole transfer.
    logic        wr_q;
    logic [1:0]  slot_q;
    logic [19:0] addr_q;

    // Single data register shared by both directions: buffer word on a store,
    // memory word on a load.
    logic [71:0] data_q;

    logic accept;
    logic tmo_hit;

    assign accept = cmd_valid && (state == ST_IDLE);

    //--------------------------------------------------------------------
    // Memory request timeout
    //--------------------------------------------------------------------
`ifdef EXTBUS_XFER_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    // Counter is held at zero outside MREQ, so it is always zero on MREQ entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= 8'd0;
        end else if (state != ST_MREQ) begin
            tmo_cnt <= 8'd0;
        end else if (!mem_ack) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // The 255th un-acked MREQ cycle is the one where the counter still reads 254;
    // the edge closing it brings the counter to 255 and leaves MREQ.
    assign tmo_hit = (state == ST_MREQ) && !mem_ack && (tmo_cnt == 8'd254);

    // A timeout always lands directly in DONE, so a registered copy of tmo_hit
    // is high exactly during that DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= tmo_hit;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    //--------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    //--------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = cmd_write ? ST_XRD : ST_MREQ;
                end
            end
            ST_XRD: begin
                state_nxt = ST_MREQ;
            end
            ST_MREQ: begin
                if (mem_ack) begin
                    state_nxt = wr_q ? ST_DONE : ST_XWR;
                end else if (tmo_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_XWR: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        ECX       = 1'b0;
        WX        = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_XRD: begin
                ECX = 1'b1;
            end
            ST_MREQ: begin
                mem_req = 1'b1;
                mem_we  = wr_q;
            end
            ST_XWR: begin
                ECX = 1'b1;
                WX  = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Address and data buses are driven straight from the context registers,
    // which keeps them stable across the whole request without extra muxing.
    assign AX        = slot_q;
    assign xdata_o   = data_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

    //--------------------------------------------------------------------
    // Command context and data register
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= 1'b0;
            slot_q <= 2'd0;
            addr_q <= 20'd0;
        end else if (accept) begin
            wr_q   <= cmd_write;
            slot_q <= cmd_slot;
            addr_q <= cmd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= 72'd0;
        end else if (state == ST_XRD) begin
            data_q <= xdata_i;
        end else if ((state == ST_MREQ) && mem_ack && !wr_q) begin
            data_q <= mem_rdata;
        end
    end

    //--------------------------------------------------------------------
    // Protocol properties
    //--------------------------------------------------------------------
    a_no_overlap : assert property (@(posedge clk) disable iff (reset)
        !(mem_req && ECX));

    a_req_hold : assert property (@(posedge clk) disable iff (reset)
        (mem_req && !mem_ack && !tmo_hit) |=>
            (mem_req && $stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

    a_done_pulse : assert property (@(posedge clk) disable iff (reset)
        done |=> !done);

endmodule

// File: tb/tb_extbus_xfer.sv
// tb_extbus_xfer: directed and randomized checks of extbus_xfer against a word-level model.
// Latency: n/a (testbench).
// Backpressure: memory responder acks after a programmable number of wait cycles.

module tb_extbus_xfer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_slot;
    logic [19:0] cmd_addr;
    logic        done;
    logic        err;
    logic [1:0]  AX;
    logic        ECX;
    logic        WX;
    logic [71:0] xdata_o;
    logic [71:0] xdata_i;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [71:0] mem_wdata;
    logic [71:0] mem_rdata;
    logic        mem_ack;

    extbus_xfer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_slot  (cmd_slot),
        .cmd_addr  (cmd_addr),
        .done      (done),
        .err       (err),
        .AX        (AX),
        .ECX       (ECX),
        .WX        (WX),
        .xdata_o   (xdata_o),
        .xdata_i   (xdata_i),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    //--------------------------------------------------------------------
    // Initial contents shared by the environment and the model
    //--------------------------------------------------------------------
    function automatic logic [71:0] buf_init(input int i);
        if (i == 2) return 72'hA5_0123456789ABCDEF;
        return {8'(i) + 8'h10, 64'h1111_2222_3333_0000 + 64'(i)};
    endfunction

    function automatic logic [71:0] mem_init(input logic [7:0] j);
        if (j == 8'h22) return 72'h3C_FEDCBA9876543210;
        return {j ^ 8'hC3, 32'hCAFE0000 + {24'h0, j}, {4{j}}};
    endfunction

    //--------------------------------------------------------------------
    // Environment: buffer X port and memory (indexed by the low address byte)
    //--------------------------------------------------------------------
    logic [71:0] buf_env [4];
    logic [71:0] mem_env [256];
    logic [19:0] last_ack_addr = 20'd0;
    bit          ack_en    = 1'b0;
    bit          spur_ack  = 1'b0;
    int          ack_delay = 0;
    int          req_cnt   = 0;

    assign xdata_i   = buf_env[AX];
    assign mem_rdata = mem_env[mem_addr[7:0]];
    assign mem_ack   = spur_ack | (ack_en & mem_req & (req_cnt == ack_delay));

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) buf_env[i] <= buf_init(i);
            for (int j = 0; j < 256; j++) mem_env[j] <= mem_init(8'(j));
        end else begin
            if (ECX && WX) buf_env[AX] <= xdata_o;
            if (mem_req && mem_ack && mem_we) mem_env[mem_addr[7:0]] <= mem_wdata;
        end
        if (mem_req && mem_ack) last_ack_addr <= mem_addr;
    end

    // Number of completed un-acked request cycles in the current request.
    always @(posedge clk) begin
        if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
        else                     req_cnt <= 0;
    end

    // Activity counters, one count per clock cycle the signal was high.
    int ecx_cnt  = 0;
    int wx_cnt   = 0;
    int done_cnt = 0;
    int mreq_cyc = 0;
    int viol_cnt = 0;

    always @(posedge clk) begin
        if (ECX)            ecx_cnt  <= ecx_cnt + 1;
        if (WX)             wx_cnt   <= wx_cnt + 1;
        if (done)           done_cnt <= done_cnt + 1;
        if (mem_req)        mreq_cyc <= mreq_cyc + 1;
        if (mem_req && ECX) viol_cnt <= viol_cnt + 1;
    end

    //--------------------------------------------------------------------
    // Reference model: buffer and memory contents after each transfer
    //--------------------------------------------------------------------
    logic [71:0] exp_buf [4];
    logic [71:0] exp_mem [256];

    task automatic model_init();
        for (int i = 0; i < 4; i++) exp_buf[i] = buf_init(i);
        for (int j = 0; j < 256; j++) exp_mem[j] = mem_init(8'(j));
    endtask

    task automatic model_xfer(input bit wr, input logic [1:0] sl, input logic [19:0] ad);
        if (wr) exp_mem[ad[7:0]] = exp_buf[sl];
        else    exp_buf[sl]      = exp_mem[ad[7:0]];
    endtask

    // Generic transfer: issue, measure latency, compare results against the model.
    task automatic xfer(input bit wr, input logic [1:0] sl, input logic [19:0] ad, input int dly);
        int n;
        int e0;
        int w0;
        int d0;
        @(negedge clk);
        e0 = ecx_cnt; w0 = wx_cnt; d0 = done_cnt;
        ack_en = 1'b1; ack_delay = dly;
        cmd_valid = 1'b1; cmd_write = wr; cmd_slot = sl; cmd_addr = ad;
        chk("rnd_ready_idle", 72'(cmd_ready), 72'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rnd_ready_busy", 72'(cmd_ready), 72'd0);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rnd_latency", 72'(n), 72'(3 + dly));
        chk("rnd_err", 72'(err), 72'd0);
        model_xfer(wr, sl, ad);
        chk("rnd_ack_addr", 72'(last_ack_addr), 72'(ad));
        chk("rnd_buf", buf_env[sl], exp_buf[sl]);
        chk("rnd_mem", mem_env[ad[7:0]], exp_mem[ad[7:0]]);
        @(negedge clk);
        chk("rnd_ecx_cycles", 72'(ecx_cnt - e0), 72'd1);
        chk("rnd_wx_cycles", 72'(wx_cnt - w0), wr ? 72'd0 : 72'd1);
        chk("rnd_done_cycles", 72'(done_cnt - d0), 72'd1);
    endtask

    //--------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------
    initial begin
        int n;
        int m0;
        int e0;
        int w0;
        int d0;

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slot = 2'd0; cmd_addr = 20'd0;
        model_init();
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_ready", 72'(cmd_ready), 72'd1);
        chk("rst_done", 72'(done), 72'd0);
        chk("rst_err", 72'(err), 72'd0);
        chk("rst_mem_req", 72'(mem_req), 72'd0);
        chk("rst_mem_we", 72'(mem_we), 72'd0);
        chk("rst_ecx", 72'(ECX), 72'd0);
        chk("rst_wx", 72'(WX), 72'd0);
        chk("rst_ax", 72'(AX), 72'd0);
        chk("rst_mem_addr", 72'(mem_addr), 72'd0);
        chk("rst_data", xdata_o, 72'd0);
        reset = 1'b0;

        // Store, zero-wait memory: slot 2 -> address 0x00010
        @(negedge clk);
        ack_en = 1'b1; ack_delay = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slot = 2'd2; cmd_addr = 20'h00010;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("st_c1_ecx", 72'(ECX), 72'd1);
        chk("st_c1_wx", 72'(WX), 72'd0);
        chk("st_c1_ax", 72'(AX), 72'd2);
        chk("st_c1_req", 72'(mem_req), 72'd0);
        @(negedge clk);
        chk("st_c2_req", 72'(mem_req), 72'd1);
        chk("st_c2_we", 72'(mem_we), 72'd1);
        chk("st_c2_addr", 72'(mem_addr), 72'h00010);
        chk("st_c2_wdata", mem_wdata, 72'hA5_0123456789ABCDEF);
        chk("st_c2_ecx", 72'(ECX), 72'd0);
        @(negedge clk);
        chk("st_c3_done", 72'(done), 72'd1);
        chk("st_c3_err", 72'(err), 72'd0);
        chk("st_c3_req", 72'(mem_req), 72'd0);
        model_xfer(1'b1, 2'd2, 20'h00010);
        chk("st_mem", mem_env[8'h10], 72'hA5_0123456789ABCDEF);

        // Load, 3 wait cycles: address 0x00022 -> slot 1
        @(negedge clk);
        ack_delay = 3;
        m0 = mreq_cyc;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_slot = 2'd1; cmd_addr = 20'h00022;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("ld_req_hi", 72'(mem_req), 72'd1);
            chk("ld_we_lo", 72'(mem_we), 72'd0);
            chk("ld_ecx_lo", 72'(ECX), 72'd0);
        end
        @(negedge clk);
        chk("ld_xwr_req", 72'(mem_req), 72'd0);
        chk("ld_xwr_ecx", 72'(ECX), 72'd1);
        chk("ld_xwr_wx", 72'(WX), 72'd1);
        chk("ld_xwr_ax", 72'(AX), 72'd1);
        chk("ld_xwr_data", xdata_o, 72'h3C_FEDCBA9876543210);
        chk("ld_req_cycles", 72'(mreq_cyc - m0), 72'd4);
        @(negedge clk);
        chk("ld_done", 72'(done), 72'd1);
        chk("ld_err", 72'(err), 72'd0);
        model_xfer(1'b0, 2'd1, 20'h00022);
        chk("ld_buf", buf_env[1], exp_buf[1]);

        // Back-to-back with cmd_valid held high
        @(negedge clk);
        ack_delay = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slot = 2'd0; cmd_addr = 20'h0ABCD;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("b2b_ready_busy", 72'(cmd_ready), 72'd0);
        end
        chk("b2b_first_done", 72'(done), 72'd1);
        model_xfer(1'b1, 2'd0, 20'h0ABCD);
        cmd_write = 1'b0; cmd_slot = 2'd3; cmd_addr = 20'h40055; ack_delay = 1;
        @(negedge clk);
        chk("b2b_ready_after_done", 72'(cmd_ready), 72'd1);
        @(negedge clk);
        chk("b2b_second_accepted", 72'(mem_req), 72'd1);
        chk("b2b_ready_second", 72'(cmd_ready), 72'd0);
        cmd_valid = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_latency", 72'(n), 72'd4);
        model_xfer(1'b0, 2'd3, 20'h40055);
        chk("b2b_mem", mem_env[8'hCD], exp_mem[8'hCD]);
        chk("b2b_buf", buf_env[3], exp_buf[3]);

        // Spurious ack in IDLE
        @(negedge clk);
        d0 = done_cnt;
        spur_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("spur_idle_ready", 72'(cmd_ready), 72'd1);
            chk("spur_idle_req", 72'(mem_req), 72'd0);
        end
        spur_ack = 1'b0;
        @(negedge clk);
        chk("spur_idle_no_done", 72'(done_cnt - d0), 72'd0);

        // Spurious ack during XRD of a store
        ack_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slot = 2'd3; cmd_addr = 20'h00777;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("spur_xrd_ecx", 72'(ECX), 72'd1);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        chk("spur_xrd_still_mreq", 72'(mem_req), 72'd1);
        chk("spur_xrd_no_done", 72'(done), 72'd0);
        ack_en = 1'b1; ack_delay = 2;
        n = 2;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("spur_xrd_latency", 72'(n), 72'd5);
        model_xfer(1'b1, 2'd3, 20'h00777);
        chk("spur_xrd_mem", mem_env[8'h77], exp_mem[8'h77]);

        // Reset during the 2nd MREQ cycle of a load
        @(negedge clk);
        ack_en = 1'b0;
        e0 = ecx_cnt; w0 = wx_cnt; d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_slot = 2'd0; cmd_addr = 20'h00033;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstm_in_mreq", 72'(mem_req), 72'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_init();
        chk("rstm_idle", 72'(cmd_ready), 72'd1);
        chk("rstm_req_lo", 72'(mem_req), 72'd0);
        chk("rstm_data_clr", xdata_o, 72'd0);
        ack_en = 1'b1; ack_delay = 0; spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        chk("rstm_no_done", 72'(done_cnt - d0), 72'd0);
        chk("rstm_no_ecx", 72'(ecx_cnt - e0), 72'd0);
        chk("rstm_no_wx", 72'(wx_cnt - w0), 72'd0);
        chk("rstm_buf", buf_env[0], exp_buf[0]);

`ifdef EXTBUS_XFER_TIMEOUT_EN
        // No ack: request times out after 255 cycles
        @(negedge clk);
        ack_en = 1'b0;
        m0 = mreq_cyc; w0 = wx_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_slot = 2'd2; cmd_addr = 20'h00050;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 72'(n), 72'd256);
        chk("tmo_err", 72'(err), 72'd1);
        chk("tmo_req_cycles", 72'(mreq_cyc - m0), 72'd255);
        @(negedge clk);
        chk("tmo_err_pulse", 72'(err), 72'd0);
        chk("tmo_no_xwr", 72'(wx_cnt - w0), 72'd0);
        chk("tmo_buf", buf_env[2], exp_buf[2]);
`else
        // No ack: request stays pending, err stays low
        @(negedge clk);
        ack_en = 1'b0;
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_slot = 2'd2; cmd_addr = 20'h00050;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (300) @(negedge clk);
        chk("wait_req_hi", 72'(mem_req), 72'd1);
        chk("wait_err_lo", 72'(err), 72'd0);
        chk("wait_no_done", 72'(done_cnt - d0), 72'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_init();
`endif

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 20'($urandom), $urandom_range(0, 4));
        end

        chk("no_req_ecx_overlap", 72'(viol_cnt), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
